// File: rtl/bit_serializer_pkg.sv
// Shared types and constants for the bit serializer.
// State encoding lives here so every file agrees on it.
package bit_serializer_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SHIFT  = ST_SHIFT,
    PARITY = ST_PARITY
  } state_t;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/bit_serializer_par.sv
// Even-parity generator: XOR reduction of one data word.
// Only instantiated when BIT_SERIALIZER_PARITY_EN is defined.
module bit_serializer_par #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  output logic             parity
);

  assign parity = ^data;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with valid/ready load handshake.
// Define BIT_SERIALIZER_PARITY_EN to append an even-parity bit per word.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             signal,
  output logic             bit_valid,
  output logic             word_done
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             last_data;
  logic             final_cyc;
  logic             accept;

  assign last_data = (state == SHIFT) && (cnt == LAST);
  assign accept    = load_valid && load_ready;

`ifdef BIT_SERIALIZER_PARITY_EN
  logic par_bit;
  logic par_q;

  bit_serializer_par #(
    .WIDTH (WIDTH)
  ) u_par (
    .data   (data_in),
    .parity (par_bit)
  );

  assign final_cyc = (state == PARITY);
`else
  assign final_cyc = last_data;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = SHIFT;
      end
      SHIFT: begin
        if (last_data) begin
`ifdef BIT_SERIALIZER_PARITY_EN
          state_nx = PARITY;
`else
          state_nx = accept ? SHIFT : IDLE;
`endif
        end
      end
`ifdef BIT_SERIALIZER_PARITY_EN
      PARITY: begin
        state_nx = accept ? SHIFT : IDLE;
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  // Shift register, bit counter and captured parity
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_q <= 1'b0;
`endif
    end else if (accept) begin
      shreg <= data_in;
      cnt   <= '0;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_q <= par_bit;
`endif
    end else if (state == SHIFT) begin
      if (MSB_FIRST != 0) begin
        shreg <= {shreg[WIDTH-2:0], 1'b0};
      end else begin
        shreg <= {1'b0, shreg[WIDTH-1:1]};
      end
      if (!last_data) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Outputs decoded from state and datapath
  always_comb begin
    signal     = 1'b0;
    bit_valid  = 1'b0;
    load_ready = 1'b0;
    word_done  = final_cyc;
    unique case (state)
      IDLE: begin
        load_ready = 1'b1;
      end
      SHIFT: begin
        bit_valid  = 1'b1;
        load_ready = final_cyc;
        signal     = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
      end
`ifdef BIT_SERIALIZER_PARITY_EN
      PARITY: begin
        bit_valid  = 1'b1;
        load_ready = 1'b1;
        signal     = par_q;
      end
`endif
      default: begin
        signal = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench: MSB-first and LSB-first instances share stimulus.
// Expected bits come from word arithmetic, not from the RTL structure.
module tb_bit_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       load_valid = 1'b0;
  logic       rdy_m, sig_m, bv_m, wd_m;
  logic       rdy_l, sig_l, bv_l, wd_l;
  int         checks = 0;
  int         errors = 0;

`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut_m (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .load_valid (load_valid),
    .load_ready (rdy_m),
    .signal     (sig_m),
    .bit_valid  (bv_m),
    .word_done  (wd_m)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut_l (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .load_valid (load_valid),
    .load_ready (rdy_l),
    .signal     (sig_l),
    .bit_valid  (bv_l),
    .word_done  (wd_l)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] w, input int i,
                                   input bit msb);
    if (i == 8) return ^w;
    return msb ? ((w >> (7 - i)) & 8'h1) != 0 : ((w >> i) & 8'h1) != 0;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_sig_m"}, 32'(sig_m), 0);
    check({tag, "_bv_m"}, 32'(bv_m), 0);
    check({tag, "_rdy_m"}, 32'(rdy_m), 1);
    check({tag, "_wd_m"}, 32'(wd_m), 0);
    check({tag, "_sig_l"}, 32'(sig_l), 0);
    check({tag, "_bv_l"}, 32'(bv_l), 0);
    check({tag, "_rdy_l"}, 32'(rdy_l), 1);
    check({tag, "_wd_l"}, 32'(wd_l), 0);
  endtask

  // Expects word w accepted at the coming edge; checks each serial cycle.
  task automatic expect_word(input string tag, input logic [7:0] w,
                             input bit hold_en, input logic [7:0] hold_w,
                             input bit offer, input logic [7:0] next_w);
    for (int i = 0; i < NB; i++) begin
      bit fin;
      @(negedge clk);
      fin = (i == NB - 1);
      check($sformatf("%s_sig_m%0d", tag, i), 32'(sig_m),
            32'(exp_bit(w, i, 1'b1)));
      check($sformatf("%s_sig_l%0d", tag, i), 32'(sig_l),
            32'(exp_bit(w, i, 1'b0)));
      check($sformatf("%s_bv%0d", tag, i), 32'({bv_m, bv_l}), 32'h3);
      check($sformatf("%s_wd%0d", tag, i), 32'({wd_m, wd_l}),
            fin ? 32'h3 : 32'h0);
      check($sformatf("%s_rdy%0d", tag, i), 32'({rdy_m, rdy_l}),
            fin ? 32'h3 : 32'h0);
      if (i == 0 && hold_en) data_in = hold_w;
      if (fin) begin
        load_valid = offer;
        data_in    = next_w;
      end
    end
  endtask

  initial begin
    logic [7:0] w;
    logic [7:0] nxt;
    bit         b2b;

    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_idle("reset");

    // 8'h90 single word, then idle
    load_valid = 1'b1;
    data_in    = 8'h90;
    expect_word("w90", 8'h90, 1'b0, 8'h00, 1'b0, 8'h00);
    @(negedge clk);
    check_idle("after90");

    // Back-to-back A5 then 3C
    load_valid = 1'b1;
    data_in    = 8'hA5;
    expect_word("wA5", 8'hA5, 1'b0, 8'h00, 1'b1, 8'h3C);
    expect_word("w3C", 8'h3C, 1'b0, 8'h00, 1'b0, 8'h00);
    @(negedge clk);
    check_idle("after3C");

    // Reset on the third bit of FF, with a coincident load_valid
    load_valid = 1'b1;
    data_in    = 8'hFF;
    @(negedge clk);
    load_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_bit3", 32'({sig_m, sig_l, bv_m, wd_m}), 32'hE);
    rst        = 1'b1;
    load_valid = 1'b1;
    data_in    = 8'hAA;
    @(negedge clk);
    rst        = 1'b0;
    load_valid = 1'b0;
    check_idle("rst_mid");
    @(negedge clk);
    check_idle("rst_drop");

    // 55 held valid while busy on C3
    load_valid = 1'b1;
    data_in    = 8'hC3;
    expect_word("wC3", 8'hC3, 1'b1, 8'h55, 1'b1, 8'h55);
    expect_word("w55", 8'h55, 1'b0, 8'h00, 1'b0, 8'h00);
    @(negedge clk);
    check_idle("after55");

    // 8'h01 (LSB-first instance yields 1 then zeros)
    load_valid = 1'b1;
    data_in    = 8'h01;
    expect_word("w01", 8'h01, 1'b0, 8'h00, 1'b0, 8'h00);
    @(negedge clk);
    check_idle("after01");

`ifdef BIT_SERIALIZER_PARITY_EN
    check("par07_model", 32'(exp_bit(8'h07, 8, 1'b1)), 32'h1);
    load_valid = 1'b1;
    data_in    = 8'h07;
    expect_word("w07", 8'h07, 1'b0, 8'h00, 1'b0, 8'h00);
    @(negedge clk);
    check_idle("after07");
`endif

    // Random words with random back-to-back and gaps
    w          = 8'($urandom);
    load_valid = 1'b1;
    data_in    = w;
    for (int k = 0; k < 24; k++) begin
      nxt = 8'($urandom);
      b2b = bit'($urandom_range(0, 1));
      expect_word($sformatf("rnd%0d", k), w, 1'b0, 8'h00, b2b, nxt);
      if (!b2b) begin
        @(negedge clk);
        check_idle($sformatf("rnd_idle%0d", k));
        repeat ($urandom_range(0, 2)) @(negedge clk);
        load_valid = 1'b1;
        data_in    = nxt;
      end
      w = nxt;
    end
    load_valid = 1'b0;
    repeat (NB + 2) @(negedge clk);
    check_idle("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
